// File: rtl/pixelbox_pkg.sv
// pixelbox_pkg: shared pixel-pipeline constants and address-width helper.
package pixelbox_pkg;
  localparam int DEF_DATA_WIDTH = 24;
  localparam int DEF_MAX_DELAY = 1024;
  function automatic int aw_of(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/pixel_delay_ram_if.sv
// pixel_delay_ram_if: sample stream, delay control and status of the pixel delay line.
interface pixel_delay_ram_if #(
  parameter int DATA_WIDTH = pixelbox_pkg::DEF_DATA_WIDTH,
  parameter int MAX_DELAY = pixelbox_pkg::DEF_MAX_DELAY,
  parameter int CNT_WIDTH = 16
);
  localparam int AW = pixelbox_pkg::aw_of(MAX_DELAY);
  logic i_valid;
  logic [DATA_WIDTH-1:0] i_data;
  logic [AW:0] i_delay;
  logic i_delay_we;
  logic i_flush;
  logic o_valid;
  logic [DATA_WIDTH-1:0] o_data;
  logic o_ready;
  logic [CNT_WIDTH-1:0] o_delay_cnt;
  modport master(output i_valid, i_data, i_delay, i_delay_we, i_flush,
                 input o_valid, o_data, o_ready, o_delay_cnt);
  modport slave(input i_valid, i_data, i_delay, i_delay_we, i_flush,
                output o_valid, o_data, o_ready, o_delay_cnt);
endinterface

// File: rtl/sdp_ram.sv
// sdp_ram: simple dual-port RAM, synchronous read, no reset (block-RAM inferable).
module sdp_ram #(
  parameter int WIDTH = 24,
  parameter int AW = 10
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem [0:(1<<AW)-1];
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/pixel_delay_ram.sv
// pixel_delay_ram: programmable delay line counted in valid samples, 1-clock latency.
module pixel_delay_ram import pixelbox_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_DELAY = DEF_MAX_DELAY,
  parameter int CNT_WIDTH = 16
) (
  input logic clk,
  input logic rst_n,
  pixel_delay_ram_if.slave bus
);
  localparam int AW = aw_of(MAX_DELAY);
  localparam logic [AW-1:0] TOP = AW'(MAX_DELAY - 1);
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, stored_q, stored_d, d_q, d_d;
  logic v_q, v_d, rdy_q, byp_q;
  logic [DATA_WIDTH-1:0] ram_rd, byp_data_q, hold_q, o_data;
  logic [CNT_WIDTH-1:0] cnt_q;
  // a flush coinciding with a sample leaves only that sample as history
  always_comb begin
    v_d = bus.i_valid && (bus.i_flush ? d_q == '0 : stored_q >= d_q);
    wr_ptr_d = bus.i_valid ? wr_ptr_q + AW'(1) : wr_ptr_q;
    stored_d = bus.i_flush ? AW'(bus.i_valid)
             : (bus.i_valid && stored_q != TOP) ? stored_q + AW'(1) : stored_q;
    d_d = !bus.i_delay_we ? d_q : (bus.i_delay > {1'b0, TOP}) ? TOP : bus.i_delay[AW-1:0];
    o_data = !v_q ? hold_q : byp_q ? byp_data_q : ram_rd;
  end
  sdp_ram #(.WIDTH(DATA_WIDTH), .AW(AW)) u_ram (
    .clk(clk),
    .we_i(bus.i_valid),
    .waddr_i(wr_ptr_q),
    .wdata_i(bus.i_data),
    .raddr_i(wr_ptr_q - d_q),
    .rdata_o(ram_rd)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      stored_q <= '0;
      d_q <= '0;
      v_q <= 1'b0;
      rdy_q <= 1'b0;
      byp_q <= 1'b0;
      byp_data_q <= '0;
      hold_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      stored_q <= stored_d;
      d_q <= d_d;
      v_q <= v_d;
      rdy_q <= stored_q >= d_q;
      byp_q <= d_q == '0;
      byp_data_q <= bus.i_data;
      hold_q <= o_data;
      cnt_q <= cnt_q + CNT_WIDTH'(v_d);
    end
  end
  assign bus.o_valid = v_q;
  assign bus.o_data = o_data;
  assign bus.o_ready = rdy_q;
  assign bus.o_delay_cnt = cnt_q;
endmodule

// File: tb/tb_pixel_delay_ram.sv
// tb_pixel_delay_ram: vector table, directed corner sequences and random stimulus vs a sample-history model.
module tb_pixel_delay_ram;
  localparam int DW = 24, MD = 1024, CW = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  pixel_delay_ram_if #(.DATA_WIDTH(DW), .MAX_DELAY(MD), .CNT_WIDTH(CW)) bus();
  pixel_delay_ram #(.DATA_WIDTH(DW), .MAX_DELAY(MD), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  int n_chk = 0, n_pass = 0;
  int m_d, m_stored, m_cnt;
  logic m_ov, m_rdy;
  logic [DW-1:0] m_od;
  logic [DW-1:0] hist[$];
  typedef struct {
    logic v; logic [DW-1:0] d; logic [10:0] dl; logic we;
    logic ev; logic [DW-1:0] ed; logic er;
  } vec_t;
  vec_t tbl[6];
  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask
  // model: delayed sample is the one D valid samples back in the history since reset
  task automatic step(input logic v, input logic [DW-1:0] dat, input logic [10:0] dl = '0,
                      input logic we = 1'b0, input logic fl = 1'b0);
    bit nv;
    bus.i_valid = v; bus.i_data = dat; bus.i_delay = dl; bus.i_delay_we = we; bus.i_flush = fl;
    @(posedge clk);
    nv = v && (fl ? m_d == 0 : m_stored >= m_d);
    m_rdy = m_stored >= m_d;
    if (nv) begin
      m_od = (m_d == 0) ? dat : hist[hist.size() - m_d];
      m_cnt = (m_cnt + 1) % (1 << CW);
    end
    m_ov = nv;
    if (v) hist.push_back(dat);
    if (fl) m_stored = int'(v);
    else if (v && m_stored < MD - 1) m_stored++;
    if (we) m_d = (dl > MD - 1) ? MD - 1 : int'(dl);
    #1;
    chk("o_valid", bus.o_valid, m_ov);
    chk("o_data", bus.o_data, m_od);
    chk("o_ready", bus.o_ready, m_rdy);
    chk("o_delay_cnt", bus.o_delay_cnt, m_cnt);
  endtask
  task automatic do_reset();
    bus.i_valid = 0; bus.i_data = '0; bus.i_delay = '0; bus.i_delay_we = 0; bus.i_flush = 0;
    rst_n = 1'b0;
    #1;
    chk("rst_o_valid", bus.o_valid, 0);
    chk("rst_o_data", bus.o_data, 0);
    chk("rst_o_ready", bus.o_ready, 0);
    chk("rst_o_delay_cnt", bus.o_delay_cnt, 0);
    m_d = 0; m_stored = 0; m_cnt = 0; m_ov = 0; m_rdy = 0; m_od = '0;
    hist.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask
  initial begin
    int first, lows;
    tbl[0] = '{1, 24'hA5A5A5, 0, 0, 1, 24'hA5A5A5, 1};
    tbl[1] = '{1, 24'h123456, 0, 0, 1, 24'h123456, 1};
    tbl[2] = '{0, 24'h0, 0, 0, 0, 24'h123456, 1};
    tbl[3] = '{0, 24'h0, 11'd2000, 1, 0, 24'h123456, 1};
    tbl[4] = '{0, 24'h0, 0, 0, 0, 24'h123456, 0};
    tbl[5] = '{1, 24'h7, 0, 0, 0, 24'h123456, 0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].dl, tbl[i].we);
      chk($sformatf("tbl%0d_valid", i), bus.o_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_data", i), bus.o_data, tbl[i].ed);
      chk($sformatf("tbl%0d_ready", i), bus.o_ready, tbl[i].er);
    end
    do_reset();
    step(0, 0, 11'd640, 1);
    first = -1;
    for (int k = 0; k < 700; k++) begin
      step(1, DW'(k));
      if (bus.o_valid && first < 0) begin
        first = k;
        chk("d640_first_data", bus.o_data, 0);
      end
    end
    chk("d640_first_k", first, 640);
    chk("d640_last_data", bus.o_data, 699 - 640);
    do_reset();
    step(0, 0, 11'd3, 1);
    for (int n = 1; n <= 30; n++) begin
      step(1, DW'(n));
      chk("d3_valid", bus.o_valid, n > 3);
      if (n > 3) chk("d3_data", bus.o_data, n - 3);
      step(0, 0);
      chk("d3_idle_valid", bus.o_valid, 0);
      step(0, 0);
    end
    do_reset();
    step(0, 0, 11'd10, 1);
    for (int n = 0; n < 20; n++) step(1, DW'(n));
    step(1, 20, 11'd5, 1);
    lows = 0;
    for (int n = 21; n <= 30; n++) begin
      step(1, DW'(n));
      lows += int'(!bus.o_valid);
    end
    chk("dec_lows", lows, 0);
    chk("dec_data", bus.o_data, 25);
    do_reset();
    step(0, 0, 11'd5, 1);
    for (int n = 0; n < 7; n++) step(1, DW'(n));
    step(0, 0, 11'd10, 1);
    lows = 0;
    for (int n = 7; n <= 20; n++) begin
      step(1, DW'(n));
      lows += int'(!bus.o_valid);
    end
    chk("inc_lows", lows, 3);
    do_reset();
    step(0, 0, 11'd4, 1);
    for (int n = 0; n < 10; n++) step(1, DW'(n));
    step(1, 10, 0, 0, 1);
    lows = int'(!bus.o_valid);
    for (int n = 11; n <= 14; n++) begin
      step(1, DW'(n));
      lows += int'(!bus.o_valid);
    end
    chk("flush_lows", lows, 4);
    chk("flush_resume_data", bus.o_data, 10);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic v, we, fl;
      logic [10:0] dl;
      v = $urandom_range(0, 9) < 7;
      we = $urandom_range(0, 29) == 0;
      dl = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(0, 2047)) : 11'($urandom_range(0, 40));
      fl = $urandom_range(0, 59) == 0;
      step(v, DW'($urandom), dl, we, fl);
      if (i == 1800) do_reset();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
